uart_tx_fifo_drain: RTL
=======================

// Module: uart_tx_fifo_drain
// PURPOSE
//  UART transmitter that drains the byte FIFO directly downstream of it. When the FIFO
//  holds data, it pops one byte and serialises it on tx: 1 start bit (0), DBIT data
//  bits LSB first, then stop bit(s) (1). It repeats until fifo_empty is high.
//  Bit timing comes from an external 16x-oversampling baud tick (s_tick).
// PARAMETERS
//  DBIT     8   data bits per frame; legal range 5..8; uses fifo_data[DBIT-1:0]
//  SB_TICK  16  stop length in s_tick units: 16 = 1 stop bit, 24 = 1.5, 32 = 2; legal 16..63
// PORTS
//  clk           in   1  system clock; all state updates on posedge
//  rst_n         in   1  asynchronous, active-low reset
//  s_tick        in   1  baud tick; one-clk pulse, 16 per bit period
//  fifo_empty    in   1  FIFO empty flag; high = do not pop
//  fifo_data     in   8  FIFO read data; valid the cycle after the fifo_rd cycle
//  fifo_rd       out  1  pop strobe to the FIFO; high for exactly one clk per byte
//  tx            out  1  serial line; idles high
//  tx_busy       out  1  high whenever state != IDLE
//  tx_done_tick  out  1  one-clk pulse when the last stop tick completes
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0,
//   tick_cnt=0, bit_cnt=0, shreg=0. Takes effect immediately, including mid-frame.
//   The frame in progress is discarded. Its byte is lost and is not re-popped.
//  Registered outputs: tx is registered. fifo_rd, tx_busy and tx_done_tick are decoded
//   from registered state/counters only. There is no combinational path from inputs to outputs.
//  Counters: tick_cnt is 6 bits. bit_cnt is 3 bits. shreg is 8 bits.
//  States and transitions:
//   IDLE  : tx=1. If fifo_empty==0, go to FETCH; otherwise stay.
//   FETCH : fifo_rd=1 for this single cycle. Go to LOAD unconditionally.
//   LOAD  : shreg<=fifo_data, tick_cnt<=0. Go to START. A change on fifo_empty here is ignored.
//   START : tx=0. On s_tick: if tick_cnt==15, tick_cnt<=0, bit_cnt<=0, go to DATA;
//           else tick_cnt++.
//   DATA  : tx=shreg[0]. On s_tick: if tick_cnt==15, tick_cnt<=0, shreg>>=1, then
//           if bit_cnt==DBIT-1 go to STOP, else bit_cnt++. Otherwise tick_cnt++.
//   STOP  : tx=1. On s_tick: if tick_cnt==SB_TICK-1, pulse tx_done_tick and go to IDLE;
//           else tick_cnt++.
//  s_tick is ignored in IDLE, FETCH and LOAD. Without s_tick, every state except
//   FETCH and LOAD holds indefinitely.
//  Frame length is exactly (16*(1+DBIT)+SB_TICK) s_tick pulses, counted from entry to START.
//  Back-to-back: after STOP, IDLE samples fifo_empty in the next cycle. The inter-frame
//   gap is 3 clk (IDLE, FETCH, LOAD) plus the wait for the next s_tick.
//  fifo_rd is never asserted while fifo_empty==1 is seen in IDLE.
//  At most one pop is made per frame.
//  fifo_data bits above DBIT-1 are ignored.
// TESTING
//  1 s_tick every 4 clk; push 0x55, fifo_empty->0 -> one fifo_rd pulse, 2 clk after
//    IDLE sees non-empty; tx = 0,1,0,1,0,1,0,1,0,1 at 64 clk per bit; 1 tx_done_tick.
//  fifo_empty held 1 for 1000 clk -> fifo_rd never high, tx=1, tx_busy=0.
//  Queue 0xA3 then 0x0F -> exactly 2 fifo_rd pulses; LSB-first bits 1,1,0,0,0,1,0,1 then
//    1,1,1,1,0,0,0,0; 2 tx_done_tick; gap between frames 3 clk plus tick alignment.
//  rst_n low during DATA bit 3 of 0xFF -> tx=1 and tx_busy=0 with no clk edge; after
//    release with fifo_empty=1, stays IDLE with no fifo_rd.
//  SB_TICK=32, DBIT=7, send 0x80 -> 7 data bits all 0 (bit 7 dropped); stop high
//    for 32 ticks; total frame 160 ticks.
//  s_tick gated off during START -> tx stays 0 and tick_cnt frozen; on resume, the frame
//    completes with correct bit widths.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from an upstream FIFO and serialises them
// on tx (start, DBIT data bits LSB first, stop), timed by a 16x baud tick.
module uart_tx_fifo_drain #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_tick,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done_tick
);

   localparam int unsigned TICK_W = 6;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned SH_W   = 8;
   localparam logic [TICK_W-1:0] LAST_OS   = TICK_W'(15);
   localparam logic [TICK_W-1:0] LAST_STOP = TICK_W'(SB_TICK - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DBIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_t;

   state_t              r_state;
   logic [TICK_W-1:0]   r_tick_cnt;
   logic [BIT_W-1:0]    r_bit_cnt;
   logic [SH_W-1:0]     r_shreg;
   logic                r_tx;
   logic                r_done;

   state_t              w_state_nxt;
   logic [TICK_W-1:0]   w_tick_nxt;
   logic [BIT_W-1:0]    w_bit_nxt;
   logic [SH_W-1:0]     w_shreg_nxt;
   logic                w_tx_nxt;
   logic                w_done_nxt;

   // State, counters and registered line value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shreg    <= w_shreg_nxt;
         r_tx       <= w_tx_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Next-state and datapath decode
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shreg_nxt = r_shreg;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (!fifo_empty) w_state_nxt = FETCH;
         end
         FETCH: begin
            w_state_nxt = LOAD;
         end
         LOAD: begin
            w_shreg_nxt = fifo_data;
            w_tick_nxt  = '0;
            w_state_nxt = START;
         end
         START: begin
            if (s_tick) begin
               if (r_tick_cnt == LAST_OS) begin
                  w_tick_nxt  = '0;
                  w_bit_nxt   = '0;
                  w_state_nxt = DATA;
               end else begin
                  w_tick_nxt = r_tick_cnt + TICK_W'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (r_tick_cnt == LAST_OS) begin
                  w_tick_nxt  = '0;
                  w_shreg_nxt = r_shreg >> 1;
                  if (r_bit_cnt == LAST_BIT) w_state_nxt = STOP;
                  else                       w_bit_nxt   = r_bit_cnt + BIT_W'(1);
               end else begin
                  w_tick_nxt = r_tick_cnt + TICK_W'(1);
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (r_tick_cnt == LAST_STOP) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_tick_nxt = r_tick_cnt + TICK_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Line level follows the state being entered so tx changes with the state
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shreg_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   assign fifo_rd      = (r_state == FETCH);
   assign tx_busy      = (r_state != IDLE);
   assign tx           = r_tx;
   assign tx_done_tick = r_done;

endmodule
